// File: rtl/wts_bus_pkg.sv
// Shared types for the wave-table sound bus initiator: FSM encoding, command word layout, timeout data.
// Combinational only; no latency or backpressure of its own.
package wts_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;
  localparam int         CMD_W        = 25;

  typedef struct packed {
    logic        wrt;
    logic [15:0] adr;
    logic [7:0]  d;
  } cmd_t;

  function automatic cmd_t pack_cmd(input logic wrt, input logic [15:0] adr, input logic [7:0] d);
    cmd_t c;
    c.wrt = wrt;
    c.adr = adr;
    c.d   = d;
    return c;
  endfunction

endpackage

// File: rtl/wts_cmd_fifo.sv
// Synchronous command FIFO, 2**AW deep; head visible combinationally, so pop-to-use is same cycle.
// Pushes while full and pops while empty are ignored; full/empty come from an extra pointer wrap bit.
module wts_cmd_fifo
  import wts_bus_pkg::*;
#(
  parameter int W  = CMD_W,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_empty
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] r_mem [2**AW];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_wr_en;
  logic         w_rd_en;

  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !o_empty;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd_en) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wptr[AW-1:0]] <= i_dat;
  end

  assign o_dat   = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/wts_bus_master.sv
// WTS bus initiator: queues commands, runs one req/ack cycle at a time, reports read data or timeouts.
// req rises one cycle after a push into an empty queue; cmd_ready drops only when the queue is full.
module wts_bus_master
  import wts_bus_pkg::*;
#(
  parameter int FIFO_AW = 2,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wrt,
  input  logic [15:0] cmd_adr,
  input  logic [7:0]  cmd_d,
  output logic        rsp_valid,
  output logic [7:0]  rsp_q,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        req,
  output logic        wrt,
  output logic [15:0] adr,
  output logic [7:0]  dbo,
  input  logic        ack,
  input  logic [7:0]  dbi
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic        r_wrt;
  logic [15:0] r_adr;
  logic [7:0]  r_dbo;
  logic [7:0]  r_q;
  logic        r_rsp_vld;
  logic        r_rsp_to;

  cmd_t        w_cmd_in;
  cmd_t        w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  assign w_cmd_in = pack_cmd(cmd_wrt, cmd_adr, cmd_d);
  assign w_push   = cmd_valid && !w_full;
  assign w_pop    = (r_state == ST_IDLE) && !w_empty;

  wts_cmd_fifo #(
    .W  (CMD_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .nreset  (nreset),
    .i_push  (w_push),
    .i_dat   (w_cmd_in),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 8'd0;
      r_req     <= 1'b0;
      r_wrt     <= 1'b0;
      r_adr     <= 16'h0000;
      r_dbo     <= 8'h00;
      r_q       <= 8'h00;
      r_rsp_vld <= 1'b0;
      r_rsp_to  <= 1'b0;
    end else begin
      r_rsp_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_wrt   <= w_head.wrt;
            r_adr   <= w_head.adr;
            r_dbo   <= w_head.d;
            r_req   <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack) begin
            r_req   <= 1'b0;
            r_cnt   <= 8'd0;
            r_state <= ST_RECOVER;
            if (!r_wrt) begin
              r_q       <= dbi;
              r_rsp_vld <= 1'b1;
              r_rsp_to  <= 1'b0;
            end
          end else if (r_cnt == CNT_LAST) begin
            // Timeouts are reported for writes as well, so the source never waits forever.
            r_req     <= 1'b0;
            r_cnt     <= 8'd0;
            r_q       <= TIMEOUT_DATA;
            r_rsp_vld <= 1'b1;
            r_rsp_to  <= 1'b1;
            r_state   <= ST_RECOVER;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_RECOVER: begin
          // The responder's ack trails req; wait for it to drop so it is not mistaken for the next cycle's ack.
          if (!ack || r_cnt == CNT_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = !w_full;
  assign busy        = !w_empty || (r_state != ST_IDLE);
  assign req         = r_req;
  assign wrt         = r_wrt;
  assign adr         = r_adr;
  assign dbo         = r_dbo;
  assign rsp_valid   = r_rsp_vld;
  assign rsp_q       = r_q;
  assign rsp_timeout = r_rsp_to;

endmodule

// File: tb/tb_wts_bus_master.sv
// Bench for wts_bus_master: randomized commands against modelled I/O, memory, silent and stuck responders.
// Expected bus cycles and responses are queued at issue time and checked by independent monitors.
module tb_wts_bus_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wrt = 1'b0;
  logic [15:0] cmd_adr = 16'h0000;
  logic [7:0]  cmd_d = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_q;
  logic        rsp_timeout;
  logic        busy;
  logic        req;
  logic        wrt;
  logic [15:0] adr;
  logic [7:0]  dbo;
  logic        ack;
  logic [7:0]  dbi;

  always #5 clk = ~clk;

  wts_bus_master #(
    .FIFO_AW (2),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wrt     (cmd_wrt),
    .cmd_adr     (cmd_adr),
    .cmd_d       (cmd_d),
    .rsp_valid   (rsp_valid),
    .rsp_q       (rsp_q),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .req         (req),
    .wrt         (wrt),
    .adr         (adr),
    .dbo         (dbo),
    .ack         (ack),
    .dbi         (dbi)
  );

  typedef struct {
    logic        wrt;
    logic [15:0] adr;
    logic [7:0]  d;
    int          len;
  } bus_exp_t;

  typedef struct {
    logic       to;
    logic [7:0] q;
  } rsp_exp_t;

  bus_exp_t exp_bus_q[$];
  rsp_exp_t exp_rsp_q[$];
  int       checks = 0;
  int       errors = 0;
  int       mode = 0;     // 0: I/O responder, 1: memory responder, 2: never acks, 3: ack sticks high
  bit       flush = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] resp_data(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Responder model: ack follows req by one or two cycles depending on mode.
  logic s1, s2, stuck;
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      stuck <= 1'b0;
    end else begin
      s1 <= req;
      s2 <= s1;
      stuck <= (mode == 3) && (stuck || s1);
    end
  end
  assign ack = (mode == 0) ? s1 : (mode == 1) ? s2 : (mode == 2) ? 1'b0 : (s1 | stuck);
  assign dbi = resp_data(adr);

  // Expected behaviour of one accepted command under the current responder.
  task automatic expect_cmd(input logic w, input logic [15:0] a, input logic [7:0] d);
    bus_exp_t b;
    rsp_exp_t r;
    b.wrt = w;
    b.adr = a;
    b.d   = d;
    b.len = (mode == 2) ? TO : (mode == 1) ? 3 : 2;
    exp_bus_q.push_back(b);
    if (mode == 2) begin
      r.to = 1'b1;
      r.q  = 8'hFF;
      exp_rsp_q.push_back(r);
    end else if (!w) begin
      r.to = 1'b0;
      r.q  = resp_data(a);
      exp_rsp_q.push_back(r);
    end
  endtask

  task automatic push(input logic w, input logic [15:0] a, input logic [7:0] d, output bit acc);
    cmd_wrt   = w;
    cmd_adr   = a;
    cmd_d     = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    acc = cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (acc) expect_cmd(w, a, d);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy && !req && !ack) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", 32'(ok), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rand_phase(input int m, input int n);
    bit acc;
    mode = m;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      push(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), acc);
    end
    wait_idle();
  endtask

  // Response monitor.
  bit       rm_prev = 1'b0;
  rsp_exp_t rm_e;
  always @(negedge clk) begin
    if (rsp_valid) begin
      chk("rsp_single_cycle", 32'(rm_prev), 32'd0);
      chk("rsp_expected", 32'(exp_rsp_q.size() > 0), 32'd1);
      if (exp_rsp_q.size() > 0) begin
        rm_e = exp_rsp_q.pop_front();
        chk("rsp_q", 32'(rsp_q), 32'(rm_e.q));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(rm_e.to));
      end
    end
    rm_prev = rsp_valid;
  end

  // Bus monitor: order and content of bus cycles, stability and req width.
  bit       bm_prev = 1'b0;
  bit       bm_have = 1'b0;
  int       bm_hi = 0;
  bus_exp_t bm_cur;
  always @(negedge clk) begin
    if (flush || !nreset) begin
      bm_prev = 1'b0;
      bm_have = 1'b0;
      bm_hi   = 0;
    end else begin
      if (req && !bm_prev) begin
        chk("bus_expected", 32'(exp_bus_q.size() > 0), 32'd1);
        chk("ack_low_at_req", 32'(ack), 32'd0);
        bm_have = (exp_bus_q.size() > 0);
        if (bm_have) begin
          bm_cur = exp_bus_q.pop_front();
          chk("bus_wrt", 32'(wrt), 32'(bm_cur.wrt));
          chk("bus_adr", 32'(adr), 32'(bm_cur.adr));
          if (bm_cur.wrt) chk("bus_dbo", 32'(dbo), 32'(bm_cur.d));
        end
        bm_hi = 1;
      end else if (req) begin
        bm_hi++;
        if (bm_have) begin
          chk("bus_adr_stable", 32'(adr), 32'(bm_cur.adr));
          chk("bus_wrt_stable", 32'(wrt), 32'(bm_cur.wrt));
        end
      end else if (bm_prev && bm_have) begin
        chk("req_len", 32'(bm_hi), 32'(bm_cur.len));
      end
      bm_prev = req;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int k;
    int rec;
    bit bad;

    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_wrt", 32'(wrt), 32'd0);
    chk("rst_adr", 32'(adr), 32'h0000);
    chk("rst_dbo", 32'(dbo), 32'h00);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_q", 32'(rsp_q), 32'h00);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    nreset = 1'b1;
    @(posedge clk);
    #1;

    // Directed read on I/O responder, directed write on memory responder.
    mode = 0;
    push(1'b0, 16'h9800, 8'h00, acc);
    chk("dir_read_acc", 32'(acc), 32'd1);
    wait_idle();
    mode = 1;
    push(1'b1, 16'h1234, 8'hC3, acc);
    chk("dir_write_acc", 32'(acc), 32'd1);
    wait_idle();

    rand_phase(0, 25);
    rand_phase(1, 25);

    // Back-to-back pushes: first is popped at once, the next four fill the queue.
    mode = 1;
    for (int i = 0; i < 6; i++) begin
      push(1'b1, 16'(16'h0100 + i), 8'(8'h10 + i), acc);
      chk("fill_acc", 32'(acc), 32'(i < 5));
    end
    wait_idle();

    // Silent responder: timeouts, then a normal command proceeds.
    mode = 2;
    push(1'b0, 16'h4000, 8'h00, acc);
    wait_idle();
    rand_phase(2, 5);
    mode = 0;
    push(1'b0, 16'h4001, 8'h00, acc);
    wait_idle();

    // Ack stuck high after completion: RECOVER gives up after TO cycles.
    mode = 3;
    push(1'b0, 16'h2222, 8'h00, acc);
    for (k = 0; k < 50 && !req; k++) @(negedge clk);
    chk("stuck_req_seen", 32'(req), 32'd1);
    for (k = 0; k < 50 && req; k++) @(negedge clk);
    chk("stuck_req_fell", 32'(req), 32'd0);
    rec = 0;
    while (busy && rec < 100) begin
      rec++;
      @(negedge clk);
    end
    chk("stuck_recover_len", 32'(rec), 32'(TO));
    mode = 0;
    wait_idle();

    // Reset mid-transaction with two commands still queued.
    mode = 2;
    push(1'b0, 16'h5000, 8'h00, acc);
    push(1'b0, 16'h5001, 8'h00, acc);
    push(1'b1, 16'h5002, 8'h77, acc);
    chk("pre_reset_req", 32'(req), 32'd1);
    @(negedge clk);
    #2;
    flush = 1'b1;
    nreset = 1'b0;
    #1;
    chk("reset_req_async", 32'(req), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    exp_bus_q.delete();
    exp_rsp_q.delete();
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    flush = 1'b0;
    mode = 0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (req || busy || rsp_valid) bad = 1'b1;
    end
    chk("post_reset_quiet", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    push(1'b0, 16'h6060, 8'h00, acc);
    wait_idle();

    chk("bus_queue_drained", 32'(exp_bus_q.size()), 32'd0);
    chk("rsp_queue_drained", 32'(exp_rsp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
